// File: rtl/dmem_bridge_pkg.sv
// =============================================================================
// dmem_bridge_pkg
// Shared mips definitions used by the data-memory bridge: memory-stage request
// structures, access-size encodings and the bridge state enumeration.
// Revision: 1.0
// =============================================================================
`default_nettype none

package dmem_bridge_pkg;

   // Access size encodings carried on the bus size field
   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   // Read request from the memory stage
   typedef struct packed {
      logic        en;
      logic [31:0] addr;
      logic [1:0]  size;
   } m_r_t;

   // Write request from the memory stage (data already lane-placed)
   typedef struct packed {
      logic        en;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] data;
   } m_w_t;

   // Bridge state
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } dmem_state_t;

   // Bus-side view of one request, held for the whole transaction
   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_req_t;

endpackage

`default_nettype wire

// File: rtl/dmem_bridge.sv
// =============================================================================
// dmem_bridge
// Data-memory responder for the memory stage. Turns the single-cycle stage
// request into a handshaked SRAM-like bus transaction, stalls the pipeline
// until the data phase completes and returns right-aligned load data.
// Optional macro: DMEM_BRIDGE_PERF_EN adds perf_rd/perf_wr/perf_stall counters.
// Revision: 1.0
// =============================================================================
`default_nettype none

module dmem_bridge
   import dmem_bridge_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  m_r_t        mread,
   input  m_w_t        mwrite,
   output logic [31:0] rd,
   output logic        stall,
   output logic        req,
   output logic        wr,
   output logic [1:0]  size,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   input  logic        addr_ok,
   input  logic        data_ok,
   input  logic [31:0] rdata
`ifdef DMEM_BRIDGE_PERF_EN
   ,
   output logic [31:0] perf_rd,
   output logic [31:0] perf_wr,
   output logic [31:0] perf_stall
`endif
);

   dmem_state_t state;
   dmem_state_t state_nx;
   bus_req_t    req_q;
   bus_req_t    cur;
   bus_req_t    bus;
   logic        act;
   logic        latch;
   logic        capture;
   logic [31:0] rd_q;

   // Select the winning stage request; a write overrides a simultaneous read
   always_comb begin
      act = mread.en | mwrite.en;
      if (mwrite.en) begin
         cur = '{wr: 1'b1, size: mwrite.size, addr: mwrite.addr, wdata: mwrite.data};
      end else begin
         cur = '{wr: 1'b0, size: mread.size, addr: mread.addr, wdata: 32'd0};
      end
   end

   // Next-state and bus/stall outputs; reset forces req and stall low at once
   always_comb begin
      state_nx = state;
      req      = 1'b0;
      stall    = 1'b0;
      bus      = req_q;
      latch    = 1'b0;
      capture  = 1'b0;
      case (state)
         IDLE: begin
            bus   = cur;
            req   = act;
            stall = act;
            if (act) begin
               // Captured in both cases so WAIT knows address and direction
               latch    = 1'b1;
               state_nx = addr_ok ? WAIT : REQ;
            end
         end
         REQ: begin
            req   = 1'b1;
            stall = 1'b1;
            if (addr_ok) begin
               state_nx = WAIT;
            end
         end
         WAIT: begin
            stall = 1'b1;
            if (data_ok) begin
               capture  = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: begin
            // Stage inputs still describe the finished request; ignore them
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
      if (reset) begin
         req   = 1'b0;
         stall = 1'b0;
      end
   end

   assign wr    = bus.wr;
   assign size  = bus.size;
   assign addr  = bus.addr;
   assign wdata = bus.wdata;
   assign rd    = rd_q;

   // State register, held request and load-data register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         req_q <= '0;
         rd_q  <= 32'd0;
      end else begin
         state <= state_nx;
         if (latch) begin
            req_q <= cur;
         end
         if (capture && !req_q.wr) begin
            // Right-align the addressed lane; upper bytes are not extended
            rd_q <= rdata >> {req_q.addr[1:0], 3'b000};
         end
      end
   end

`ifdef DMEM_BRIDGE_PERF_EN
   // Completed-request and stall-cycle counters, free-running and wrapping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_rd    <= 32'd0;
         perf_wr    <= 32'd0;
         perf_stall <= 32'd0;
      end else begin
         if (capture) begin
            if (req_q.wr) begin
               perf_wr <= perf_wr + 32'd1;
            end else begin
               perf_rd <= perf_rd + 32'd1;
            end
         end
         if (stall) begin
            perf_stall <= perf_stall + 32'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory responder for the memory stage. Accepts the stage's single-cycle read/write request, converts it into a handshaked SRAM-like bus transaction, and holds the pipeline stalled until the data phase completes. Returns lane-aligned load data to the memory stage. Drives the stall request consumed by the hazard unit.

## Interface
Parameters:
- none

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high
- mread  in  m_r_t  read request from the memory stage {en, addr[31:0], size[1:0]}
- mwrite  in  m_w_t  write request from the memory stage {en, addr[31:0], size[1:0], data[31:0]}
- rd  out  32  load data, right-aligned by addr[1:0]; no extension
- stall  out  1  holds F/D/E/M stages while a request is outstanding
- req  out  1  bus request
- wr  out  1  1 = write, 0 = read
- size  out  2  0 = byte, 1 = half, 2 = word
- addr  out  32  byte address
- wdata  out  32  write data, already lane-placed by the memory stage
- addr_ok  in  1  bus accepted the address phase
- data_ok  in  1  bus completed the data phase
- rdata  in  32  bus read data, valid with data_ok

## Operation
- act = mread.en | mwrite.en. If both are set, the write wins and the read is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - req = act; wr/size/addr/wdata driven combinationally from the winning request; stall = act.
  - On act & addr_ok: go to WAIT.
  - On act & !addr_ok: latch the request into req_q and go to REQ.
- REQ:
  - req = 1, bus fields from req_q, stall = 1.
  - On addr_ok: go to WAIT.
- WAIT:
  - req = 0, stall = 1.
  - On data_ok: for reads, rd_q <= rdata >> (8*addr[1:0]); writes leave rd_q unchanged. Go to DONE.
- DONE:
  - stall = 0, req = 0, rd = rd_q. The pipeline advances at this edge.
  - Inputs are ignored, because they still carry the completed request.
  - Next state: IDLE.
- rd always shows rd_q; the memory stage samples it only in DONE.
- addr_ok and data_ok outside REQ/IDLE and WAIT respectively are protocol errors and are ignored.
- Misaligned addresses are not checked here; the exception logic filters them upstream.

## Timing
- Reset values (asynchronous): state = IDLE, req_q = 0, rd_q = 0.
- While reset is high, req and stall are forced to 0.
- Zero-wait bus (addr_ok and data_ok each asserted on first opportunity):
  - C0 IDLE, req = 1, addr_ok.
  - C1 WAIT, data_ok.
  - C2 DONE, stall = 0.
  - Stage occupancy is 3 cycles, with stall high in C0 and C1.
- Each cycle of addr_ok delay adds one REQ cycle; each cycle of data_ok delay adds one WAIT cycle.
- addr_ok and data_ok in the same cycle as req in IDLE: data_ok is not honoured until WAIT. The bus must not return data in the address-phase cycle.
- Reset mid-transaction: the FSM returns to IDLE and the outstanding transaction is abandoned. The bus slave shares the same reset.
- Back-to-back requests: a new request is first seen in the IDLE cycle after DONE.

## Configuration
- DMEM_BRIDGE_PERF_EN defined:
  - Adds outputs perf_rd, perf_wr, perf_stall (32 bits each, wrapping, reset to 0).
  - perf_rd and perf_wr increment on entry to DONE by request type.
  - perf_stall increments every cycle stall = 1.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- In the shared mips package:
  - m_r_t and m_w_t fields as listed above.
  - The 2-bit size encodings (SIZE_B, SIZE_H, SIZE_W).
  - The bridge state enum dmem_state_t.
- Single module. No sub-module; the lane shifter is a few lines inline.

## Test plan
- Word read, addr 0x1000, zero-wait bus, rdata 0xDEADBEEF: stall high for 2 cycles; DONE with rd = 0xDEADBEEF; one req pulse with wr = 0, size = 2.
- Byte read, addr 0x1003, rdata 0xAABBCCDD, addr_ok delayed 2 cycles and data_ok delayed 3 cycles: 2 REQ cycles with bus fields held stable; rd = 0x000000AA; stall high for 7 cycles total.
- Half write, addr 0x2002, data 0x12340000, with mread.en also set: wr = 1, size = 1, wdata = 0x12340000; read ignored; rd unchanged.
- Two back-to-back reads: the second req rises exactly one cycle after DONE; no duplicate request is issued for the first.
- Assert reset in WAIT: req and stall drop to 0 immediately; state is IDLE and rd = 0 after release; a later data_ok is ignored.
- With DMEM_BRIDGE_PERF_EN, running the first two scenarios: perf_rd = 2, perf_wr = 0, perf_stall = 9.
